// File: rtl/msrv32_wb_port_arbiter.sv
// msrv32_wb_port_arbiter
//   Shares the single integer register-file write port between the in-order
//   pipeline writeback and a buffered secondary result source (slow loads, CSR
//   returns). Pipeline writes win; a starvation counter forces a one-cycle
//   pipeline stall so the buffer head can drain.
//   Optional build macro MSRV32_WB_SCOREBOARD_EN adds rs1/rs2 pending lookups
//   for decode-stage RAW hazard detection.
module msrv32_wb_port_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     pipe_wr_en_in,
  input  logic [4:0]               pipe_rd_addr_in,
  input  logic [31:0]              pipe_wb_data_in,
  input  logic                     sec_valid_in,
  output logic                     sec_ready_out,
  input  logic [4:0]               sec_rd_addr_in,
  input  logic [31:0]              sec_data_in,
  output logic                     rf_wr_en_out,
  output logic [4:0]               rf_rd_addr_out,
  output logic [31:0]              rf_wr_data_out,
  output logic                     pipe_stall_out,
`ifdef MSRV32_WB_SCOREBOARD_EN
  input  logic [4:0]               rs1_addr_in,
  input  logic [4:0]               rs2_addr_in,
  output logic                     rs1_pending_out,
  output logic                     rs2_pending_out,
`endif
  output logic [$clog2(DEPTH):0]   pend_count_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT) + 1;

  logic [4:0]       buf_addr [DEPTH];
  logic [31:0]      buf_data [DEPTH];
  logic [DEPTH-1:0] buf_live;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [SC_W-1:0]  starve_cnt;
  logic [SC_W-1:0]  starve_nxt;
  logic             stall_nxt;

  logic buf_empty;
  logic head_live;
  logic pipe_req;
  logic grant_pipe;
  logic pop;
  logic accept;
  logic push;
  logic push_killed;

  // Grant decision: a forced stall slot always drains the head, otherwise the
  // pipeline wins and the buffer only uses free slots. rd=0 writes never issue.
  always_comb begin
    buf_empty     = (count == '0);
    head_live     = buf_live[rd_ptr] && !buf_empty;
    pipe_req      = pipe_wr_en_in && (pipe_rd_addr_in != 5'd0);
    grant_pipe    = !pipe_stall_out && pipe_req;
    pop           = !buf_empty && (pipe_stall_out || !pipe_req);
    sec_ready_out = !rst_in && (count < CNT_W'(DEPTH));
    accept        = sec_valid_in && sec_ready_out;
    push          = accept && (sec_rd_addr_in != 5'd0);
    push_killed   = grant_pipe && (sec_rd_addr_in == pipe_rd_addr_in);
  end

  // Starvation tracking: a live head passed over STARVE_LIMIT-1 times arms the
  // stall slot, which drains it on the following cycle.
  always_comb begin
    starve_nxt = starve_cnt;
    stall_nxt  = 1'b0;
    if (buf_empty || pop) begin
      starve_nxt = '0;
    end else if (head_live) begin
      if (starve_cnt == SC_W'(STARVE_LIMIT - 2)) begin
        stall_nxt  = 1'b1;
        starve_nxt = '0;
      end else begin
        starve_nxt = starve_cnt + 1'b1;
      end
    end
  end

  // Buffer control: pointers, occupancy and live bits; pipeline grants kill
  // matching entries, including one being pushed in the same cycle.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      buf_live <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (grant_pipe && (buf_addr[i] == pipe_rd_addr_in)) buf_live[i] <= 1'b0;
      end
      if (pop) begin
        buf_live[rd_ptr] <= 1'b0;
        rd_ptr           <= rd_ptr + 1'b1;
      end
      if (push) begin
        buf_live[wr_ptr] <= !push_killed;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Buffer payload storage; validity is carried entirely by buf_live.
  always_ff @(posedge clk_in) begin
    if (push) begin
      buf_addr[wr_ptr] <= sec_rd_addr_in;
      buf_data[wr_ptr] <= sec_data_in;
    end
  end

  // Registered write port and stall slot.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rf_wr_en_out   <= 1'b0;
      rf_rd_addr_out <= 5'd0;
      rf_wr_data_out <= 32'd0;
      pipe_stall_out <= 1'b0;
      starve_cnt     <= '0;
    end else begin
      pipe_stall_out <= stall_nxt;
      starve_cnt     <= starve_nxt;
      if (grant_pipe) begin
        rf_wr_en_out   <= 1'b1;
        rf_rd_addr_out <= pipe_rd_addr_in;
        rf_wr_data_out <= pipe_wb_data_in;
      end else if (pop) begin
        rf_wr_en_out   <= buf_live[rd_ptr];
        rf_rd_addr_out <= buf_addr[rd_ptr];
        rf_wr_data_out <= buf_data[rd_ptr];
      end else begin
        rf_wr_en_out   <= 1'b0;
      end
    end
  end

  assign pend_count_out = count;

`ifdef MSRV32_WB_SCOREBOARD_EN
  // Pending lookup over live entries plus the entry accepted this cycle.
  always_comb begin
    rs1_pending_out = push && (sec_rd_addr_in == rs1_addr_in);
    rs2_pending_out = push && (sec_rd_addr_in == rs2_addr_in);
    for (int i = 0; i < DEPTH; i++) begin
      if (buf_live[i] && (buf_addr[i] == rs1_addr_in)) rs1_pending_out = 1'b1;
      if (buf_live[i] && (buf_addr[i] == rs2_addr_in)) rs2_pending_out = 1'b1;
    end
    if (rs1_addr_in == 5'd0) rs1_pending_out = 1'b0;
    if (rs2_addr_in == 5'd0) rs2_pending_out = 1'b0;
  end
`endif

endmodule
